lut_neuron_loader: RTL and testbench
====================================

# lut_neuron_loader

Runtime-programmable truth-table neuron and its loader: it accepts a neuron's truth table as a stream of output codes, writes it into a distributed-RAM table, and then serves registered lookups with the same addressing as a fixed LUT neuron (address = concatenated fan-in code, output = quantised activation). It sits between the configuration stream (host/DMA) and the layer datapath, letting the HGCAL autoencoder swap neuron functions without resynthesis.

## Interface
- IN_BITS, 8, lookup address width (fan-in × input quantisation bits); table depth ENTRIES = 2**IN_BITS
- OUT_BITS, 2, output code width per entry
- One clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: begin a (re)load
- s_valid  input  1  table entry valid
- s_ready  output  1  loader accepts an entry this cycle
- s_data  input  OUT_BITS  entry for the current write address
- s_last  input  1  marks the final entry of the table
- busy  output  1  high in LOAD
- loaded  output  1  table complete and valid
- err  output  1  framing error latched
- lk_valid  input  1  lookup request
- lk_addr  input  IN_BITS  lookup address (M0-style code)
- lk_out_valid  output  1  lookup result valid
- lk_data  output  OUT_BITS  lookup result (M1-style code)

## Operation
- FSM states: IDLE, LOAD, READY, ERR. Reset → IDLE. All outputs are 0 on reset; the write counter is 0; table contents are not reset.
- IDLE/READY/ERR + start → LOAD: counter := 0, loaded := 0, err := 0. start during LOAD is ignored.
- LOAD: s_ready = 1, busy = 1. A beat is accepted when s_valid && s_ready. It writes s_data to table[counter], then counter += 1.
- Accepted beat with counter == ENTRIES-1 and s_last = 1 → READY, loaded := 1.
- Accepted beat with counter == ENTRIES-1 and s_last = 0 → ERR. The beat is still written.
- Accepted beat with counter < ENTRIES-1 and s_last = 1 → ERR (short table).
- ERR: err = 1, s_ready = 0, loaded = 0. Only start leaves this state.
- Lookups: in READY, lk_valid samples lk_addr. In all other states lookup requests are dropped: lk_out_valid stays 0 and lk_data holds its last value.
- Counter width is IN_BITS. It never wraps inside a load, because the final beat always exits LOAD.

## Timing
- Load throughput: one entry per cycle when s_valid is held high. A full table takes ENTRIES cycles of accepted beats.
- loaded rises in the cycle after the final accepted beat. A lookup may be issued in that same cycle.
- Lookup latency is 1 cycle: a request at edge N produces lk_out_valid/lk_data at edge N+1. The bus is fully pipelined, one result per cycle.
- lk_out_valid is a single-cycle pulse per request, with no backpressure.
- A write and a read never target the RAM in the same cycle, because lookups are only served in READY.
- Reset asserted mid-load forces IDLE and clears busy/loaded/err/lk_out_valid immediately; the partial table is discarded logically.
- start arriving in the same cycle as a lookup in READY: the lookup is served, and the state moves to LOAD on the next edge.

## Structure
- Package lut_pkg holds:
  - the state enum (IDLE, LOAD, READY, ERR)
  - localparams for default IN_BITS/OUT_BITS
  - a function computing ENTRIES
- Sub-module lut_table_ram: ENTRIES×OUT_BITS distributed RAM with one synchronous write port, one registered read port, and a rom_style/ram_style "distributed" attribute.
- The top level contains the FSM, write counter, framing check and lookup valid pipeline register.

## Test plan
- Full load of table[i] = i[1:0] with s_last on beat 255, then lookups at 0x00, 0x05, 0xFE, 0xFF → lk_data 0, 1, 2, 3 one cycle after each request; loaded = 1, err = 0.
- Back-to-back lookups on every cycle for 256 addresses → 256 consecutive lk_out_valid pulses, each with data matching its address.
- s_last asserted on beat 10 → err = 1, loaded = 0, s_ready = 0; then a start and a valid reload → READY with err cleared.
- 256 beats without s_last → ERR. A lookup at 0x00 while in ERR → no lk_out_valid.
- s_valid toggled 50% with random gaps → the table equals the sequence of accepted data, and busy is high throughout.
- Reset pulled low at beat 100 → all outputs 0 in that cycle and FSM in IDLE. After start and a full reload (all entries = 2'b11), lookups return 3.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types and sizing for the runtime-programmable LUT neuron.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam int DEF_IN_BITS  = 8;
  localparam int DEF_OUT_BITS = 2;

  function automatic int lut_entries(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Distributed-RAM truth table: synchronous write, registered read with enable.
// Read register holds its value when no read is requested; contents are never reset.
module lut_table_ram
  import lut_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic                re_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);

  localparam int ENTRIES = lut_entries(IN_BITS);

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [ENTRIES];
  logic [OUT_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_loader.sv
// Loads a neuron truth table from an entry stream, then serves 1-cycle registered lookups.
// Framing errors (short table or missing s_last) latch ERR until the next start.
module lut_neuron_loader
  import lut_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [OUT_BITS-1:0] s_data,
  input  logic                s_last,
  output logic                busy,
  output logic                loaded,
  output logic                err,
  input  logic                lk_valid,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                lk_out_valid,
  output logic [OUT_BITS-1:0] lk_data
);

  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(lut_entries(IN_BITS) - 1);

  state_e               state_q;
  logic [IN_BITS-1:0]   cnt_q;
  logic [IN_BITS-1:0]   cnt_d;
  logic                 busy_q;
  logic                 loaded_q;
  logic                 err_q;
  logic                 lk_vld_q;
  logic                 accept;
  logic                 rd_en;

  // busy_q is set exactly while in LOAD, so it doubles as s_ready.
  assign accept = s_valid && busy_q;
  assign cnt_d  = cnt_q + 1'b1;
  assign rd_en  = lk_valid && (state_q == READY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, READY, ERR: begin
          if (start) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (s_last || cnt_q == LAST_ADDR) begin
              busy_q <= 1'b0;
              if (s_last && cnt_q == LAST_ADDR) begin
                state_q  <= READY;
                loaded_q <= 1'b1;
              end else begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lk_vld_q <= 1'b0;
    else      lk_vld_q <= rd_en;
  end

  lut_table_ram #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (accept),
    .waddr_i(cnt_q),
    .wdata_i(s_data),
    .re_i   (rd_en),
    .raddr_i(lk_addr),
    .rdata_o(lk_data)
  );

  assign s_ready      = busy_q;
  assign busy         = busy_q;
  assign loaded       = loaded_q;
  assign err          = err_q;
  assign lk_out_valid = lk_vld_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Randomised bench for lut_neuron_loader against an array-based table/framing model.
module tb_lut_neuron_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [1:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       busy;
  logic       loaded;
  logic       err;
  logic       lk_valid = 1'b0;
  logic [7:0] lk_addr = '0;
  logic       lk_out_valid;
  logic [1:0] lk_data;

  int checks = 0;
  int errors = 0;

  logic [1:0] model_tab [256];
  logic [1:0] exp_lk = '0;

  always #5 clk = ~clk;

  lut_neuron_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .busy        (busy),
    .loaded      (loaded),
    .err         (err),
    .lk_valid    (lk_valid),
    .lk_addr     (lk_addr),
    .lk_out_valid(lk_out_valid),
    .lk_data     (lk_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the negedge after the loader entered LOAD.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", s_ready, 1);
    check("loaded_cleared", loaded, 0);
    check("err_cleared", err, 0);
  endtask

  // Streams beats until nbeats are accepted. last_at < 0 means s_last is never set.
  // mode 0: data = index[1:0], 1: random, 2: all ones.
  task automatic stream(input int nbeats, input int last_at, input int gap_pct, input int mode);
    int sent = 0;
    int guard = 0;
    logic v;
    logic [1:0] d;
    while (sent < nbeats && guard < 5000) begin
      guard++;
      check("busy_in_load", busy, 1);
      v = ($urandom_range(0, 99) >= gap_pct);
      case (mode)
        0:       d = 2'(sent);
        1:       d = 2'($urandom);
        default: d = 2'b11;
      endcase
      s_valid = v;
      s_data  = d;
      s_last  = (sent == last_at);
      @(negedge clk);
      if (v) begin
        model_tab[sent] = d;
        sent++;
      end
    end
    if (guard >= 5000) check("stream_timeout", 1, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_status(input string tag, input bit exp_loaded, input bit exp_err);
    check({tag, "_loaded"}, loaded, exp_loaded);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  // One request per cycle; each result is checked one cycle after its request.
  task automatic lookups(input int n, input int kind, input bit served);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       a = (i == 0) ? 8'h00 : (i == 1) ? 8'h05 : (i == 2) ? 8'hFE : 8'hFF;
        1:       a = 8'(i);
        default: a = 8'($urandom);
      endcase
      lk_valid = 1'b1;
      lk_addr  = a;
      @(negedge clk);
      if (served) exp_lk = model_tab[a];
      check("lk_out_valid", lk_out_valid, served);
      check("lk_data", lk_data, exp_lk);
    end
    lk_valid = 1'b0;
    @(negedge clk);
    check("lk_valid_drop", lk_out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_lk_out_valid", lk_out_valid, 0);
    check("rst_lk_data", lk_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lookups in IDLE are dropped.
    lookups(2, 2, 0);

    // Full load of index pattern; lookups start in the cycle loaded rises.
    pulse_start();
    stream(256, 255, 0, 0);
    expect_status("full", 1, 0);
    lookups(4, 0, 1);
    lookups(256, 1, 1);

    // start together with a lookup in READY: lookup served, then LOAD.
    lk_valid = 1'b1;
    lk_addr  = 8'h07;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lk_valid = 1'b0;
    exp_lk = model_tab[7];
    check("start_lk_valid", lk_out_valid, 1);
    check("start_lk_data", lk_data, exp_lk);
    check("start_busy", busy, 1);

    // Short table: s_last on beat 10.
    stream(11, 10, 0, 1);
    expect_status("short", 0, 1);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("err_sticky", err, 1);

    // Valid reload out of ERR.
    pulse_start();
    stream(256, 255, 0, 1);
    expect_status("reload", 1, 0);
    lookups(20, 2, 1);

    // 256 beats without s_last; lookups in ERR are dropped.
    pulse_start();
    stream(256, -1, 0, 1);
    expect_status("nolast", 0, 1);
    lookups(1, 0, 0);

    // 50% random gaps with random data.
    pulse_start();
    stream(256, 255, 50, 1);
    expect_status("gaps", 1, 0);
    lookups(256, 1, 1);

    // Reset in the middle of a load.
    pulse_start();
    stream(100, -1, 0, 1);
    #2 rst = 1'b0;
    #1;
    exp_lk = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_loaded", loaded, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_lk_out_valid", lk_out_valid, 0);
    check("mid_rst_lk_data", lk_data, exp_lk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    pulse_start();
    stream(256, 255, 0, 2);
    expect_status("ones", 1, 0);
    lookups(16, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
